// File: rtl/uart_pkg.sv
// Shared types and defaults for the bit-stream UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_e;

  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam logic [7:0]  EOT_CHAR_DEF   = 8'h04;

endpackage

// File: rtl/uart_receiver_bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with a selectable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input through the two stages.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_receiver_bit.sv
// 8N1 UART receiver on oversampled baud ticks; reduces each good frame to its LSB
// and flags the end-of-transmission character on a separate strobe.
module uart_receiver_bit
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
  parameter logic [7:0]  EOT_CHAR   = EOT_CHAR_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  output logic bit_ready,
  output logic data_out,
  output logic eot
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

  logic          rxs;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          bit_ready_q, bit_ready_d;
  logic          eot_q, eot_d;
  logic          data_q, data_d;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (rx),
    .q     (rxs)
  );

  // Next-state logic; nothing moves unless a baud tick is present.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    bit_ready_d = 1'b0;
    eot_d       = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (!rxs) begin
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            idx_d = 3'd0;
            // Still low at mid-start: a real start bit, otherwise a glitch.
            if (!rxs) begin
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            shreg_d = {rxs, shreg_q[7:1]};
            idx_d   = idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxs) begin
              state_d = IDLE;
              if (shreg_q == EOT_CHAR) begin
                eot_d = 1'b1;
              end else begin
                bit_ready_d = 1'b1;
                data_d      = shreg_q[0];
              end
            end else begin
              state_d = BREAK;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line is not a new start.
          cnt_d = '0;
          if (rxs) begin
            state_d = IDLE;
          end else begin
            state_d = BREAK;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM, counters, shift register and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      data_q      <= 1'b0;
      bit_ready_q <= 1'b0;
      eot_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      bit_ready_q <= bit_ready_d;
      eot_q       <= eot_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign data_out  = data_q;
  assign eot       = eot_q;

endmodule

// File: tb/tb_uart_receiver_bit.sv
// Self-checking bench: serial frames in, strobe events compared with a frame-level model.
module tb_uart_receiver_bit;

  localparam int BIT_CLK = 160;

  logic clk;
  logic rst;
  logic baud_tick;
  logic rx;
  logic bit_ready;
  logic data_out;
  logic eot;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int both_cnt = 0;
  int ev_q[$];
  int ev_t[$];

  uart_receiver_bit #(
    .OVERSAMPLE (16),
    .EOT_CHAR   (8'h04)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .bit_ready (bit_ready),
    .data_out  (data_out),
    .eot       (eot)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  always @(posedge clk) cyc = cyc + 1;

  // Event monitor: 0/1 = bit_ready with that data_out, 2 = eot.
  always @(negedge clk) begin
    if (rst) begin
      if (bit_ready && eot) both_cnt = both_cnt + 1;
      if (bit_ready) begin
        ev_q.push_back(data_out ? 1 : 0);
        ev_t.push_back(cyc);
      end
      if (eot) begin
        ev_q.push_back(2);
        ev_t.push_back(cyc);
      end
    end
  end

  // Frame-level reference: what a receiver must report for one frame.
  function automatic int model_event(input logic [7:0] b, input logic stop);
    if (!stop) return -1;
    if (b == 8'h04) return 2;
    return int'(b[0]);
  endfunction

  task automatic idle_clk(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = stop;
    repeat (BIT_CLK) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic clear_events();
    ev_q.delete();
    ev_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (bit_ready !== 1'b0) begin errors++; $display("FAIL reset_bit_ready: got %b expected 0", bit_ready); end
    checks++; if (eot !== 1'b0) begin errors++; $display("FAIL reset_eot: got %b expected 0", eot); end
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL reset_data_out: got %b expected 0", data_out); end
    rst = 1'b1;
    idle_clk(2 * BIT_CLK);
  endtask

  task automatic test_single_9a();
    clear_events();
    send_frame(8'h9A, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL f9a_count: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0] !== model_event(8'h9A, 1'b1)) begin errors++; $display("FAIL f9a_event: got %0d expected %0d", ev_q[0], model_event(8'h9A, 1'b1)); end
    end
    checks++; if (data_out !== 1'b0) begin errors++; $display("FAIL f9a_hold: got %b expected 0", data_out); end
  endtask

  task automatic test_back_to_back();
    clear_events();
    for (int k = 0; k < 3; k++) send_frame(8'h9B, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", ev_q.size()); end
    for (int k = 0; k < ev_q.size() && k < 3; k++) begin
      checks++; if (ev_q[k] !== 1) begin errors++; $display("FAIL b2b_event%0d: got %0d expected 1", k, ev_q[k]); end
    end
    // Frames are 10 bits of 16 ticks of 10 clk: strobes 160 ticks (1600 clk) apart.
    for (int k = 1; k < ev_t.size() && k < 3; k++) begin
      checks++; if (ev_t[k] - ev_t[k-1] !== 10 * BIT_CLK) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", k, ev_t[k] - ev_t[k-1], 10 * BIT_CLK); end
    end
  endtask

  task automatic test_eot();
    logic prev;
    prev = data_out;
    clear_events();
    send_frame(8'h04, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL eot_count: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0] !== 2) begin errors++; $display("FAIL eot_event: got %0d expected 2", ev_q[0]); end
    end
    checks++; if (data_out !== 1'b1 || prev !== 1'b1) begin errors++; $display("FAIL eot_data_hold: got %b (before %b) expected 1", data_out, prev); end
  endtask

  task automatic test_glitch();
    clear_events();
    rx = 1'b0;
    repeat (30) @(negedge clk);
    idle_clk(2 * BIT_CLK);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL glitch_no_strobe: got %0d events expected 0", ev_q.size()); end
    send_frame(8'h9A, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 1 || ev_q[0] !== 0) begin errors++; $display("FAIL glitch_recover: got %0d events (first %0d) expected 1 event of 0", ev_q.size(), (ev_q.size() > 0) ? ev_q[0] : -1); end
  endtask

  task automatic test_framing_error();
    clear_events();
    send_frame(8'h5B, 1'b0);
    idle_clk(2 * BIT_CLK);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL frame_err_no_strobe: got %0d events expected 0", ev_q.size()); end
    send_frame(8'h1A, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL frame_err_next_count: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0] !== 0) begin errors++; $display("FAIL frame_err_next_data: got %0d expected 0", ev_q[0]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hEF;
    send_frame(8'h9B, 1'b1);
    idle_clk(40);
    clear_events();
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rx = b[4];
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (data_out !== 1'b0 || bit_ready !== 1'b0 || eot !== 1'b0) begin errors++; $display("FAIL midreset_outputs: got br=%b eot=%b data=%b expected 0 0 0", bit_ready, eot, data_out); end
    rst = 1'b1;
    idle_clk(3 * BIT_CLK);
    checks++; if (ev_q.size() !== 0) begin errors++; $display("FAIL midreset_spurious: got %0d events expected 0", ev_q.size()); end
    send_frame(8'h31, 1'b1);
    idle_clk(40);
    checks++; if (ev_q.size() !== 1) begin errors++; $display("FAIL midreset_next_count: got %0d expected 1", ev_q.size()); end
    if (ev_q.size() > 0) begin
      checks++; if (ev_q[0] !== 1) begin errors++; $display("FAIL midreset_next_data: got %0d expected 1", ev_q[0]); end
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    logic [7:0] b;
    logic stop;
    int e;
    clear_events();
    for (int k = 0; k < 16; k++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (k == 5) b = 8'h04;
      e = model_event(b, stop);
      if (e >= 0) exp_q.push_back(e);
      send_frame(b, stop);
      idle_clk(stop ? $urandom_range(0, 25) : $urandom_range(30, 200));
    end
    idle_clk(40);
    checks++; if (ev_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", ev_q.size(), exp_q.size()); end
    for (int k = 0; k < ev_q.size() && k < exp_q.size(); k++) begin
      checks++; if (ev_q[k] !== exp_q[k]) begin errors++; $display("FAIL rand_event%0d: got %0d expected %0d", k, ev_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_cnt); end
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    test_reset();
    test_single_9a();
    test_back_to_back();
    test_eot();
    test_glitch();
    test_framing_error();
    test_reset_midframe();
    test_random();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
